spike_adder_node: RTL and testbench

SPIKE_ADDER_NODE -- requirements
Module: spike_adder_node

---
 rtl/snn_pkg.sv | 47 ++++
 rtl/membrane_bank.sv | 60 ++++++
 rtl/spike_adder_node.sv | 160 ++++++++++++++++
 tb/tb_spike_adder_node.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared packet layout, packet type codes and node FSM state for the SNN mesh.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package snn_pkg;

    localparam int PKT_W     = 64;
    localparam int DEST_HI   = 63;
    localparam int DEST_LO   = 60;
    localparam int SRC_HI    = 59;
    localparam int SRC_LO    = 56;
    localparam int TYPE_HI   = 55;
    localparam int TYPE_LO   = 54;
    localparam int PSUM_LO   = 0;
    localparam int POS_HI    = 5;
    localparam int POS_LO    = 1;
    localparam int SPIKE_BIT = 0;
    localparam int POS_W     = POS_HI - POS_LO + 1;

    typedef enum logic [1:0] {
        PKT_IFMAP  = 2'b00,
        PKT_FILTER = 2'b01,
        PKT_PSUM   = 2'b10,
        PKT_SPIKE  = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_UPDATE  = 2'b01,
        ST_SEND    = 2'b10
    } node_state_e;

    // Assemble an outgoing spike packet; every unused bit is zero.
    function automatic logic [PKT_W-1:0] spike_pkt(input logic [3:0]       dst,
                                                   input logic [3:0]       src,
                                                   input logic [POS_W-1:0] pos,
                                                   input logic             spike);
        logic [PKT_W-1:0] p;
        p                    = '0;
        p[DEST_HI:DEST_LO]   = dst;
        p[SRC_HI:SRC_LO]     = src;
        p[TYPE_HI:TYPE_LO]   = PKT_SPIKE;
        p[POS_HI:POS_LO]     = pos;
        p[SPIKE_BIT]         = spike;
        return p;
    endfunction

endpackage

// File: rtl/membrane_bank.sv
// Membrane potential store: one read/modify/write port with saturating add and fire-reset.
// Latency: new_pot/spike combinational from idx/add_dat; write lands on the upd_en edge.
// Backpressure: none; clear_all wins over upd_en.
module membrane_bank
    import snn_pkg::*;
#(
    parameter int                   POT_WIDTH = 16,
    parameter int                   POSITIONS = 21,
    parameter logic [POT_WIDTH-1:0] THRESHOLD = 16'd64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_all,
    input  logic                 upd_en,
    input  logic [POS_W-1:0]     idx,
    input  logic [POT_WIDTH-1:0] add_dat,
    output logic [POT_WIDTH-1:0] new_pot,
    output logic                 spike
);

    logic [POT_WIDTH-1:0] pot_q [POSITIONS];
    logic [POT_WIDTH-1:0] pot_d [POSITIONS];
    logic [POT_WIDTH-1:0] rd_dat;
    logic [POT_WIDTH:0]   raw_sum;

    // Read mux over positions; compare-based so the index width never has to match the array depth.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < POSITIONS; i++) begin
            if (idx == POS_W'(i)) rd_dat = pot_q[i];
        end
    end

    // One extra carry bit detects overflow; overflow clamps to all-ones.
    assign raw_sum = {1'b0, rd_dat} + {1'b0, add_dat};
    assign new_pot = raw_sum[POT_WIDTH] ? {POT_WIDTH{1'b1}} : raw_sum[POT_WIDTH-1:0];
    assign spike   = (new_pot >= THRESHOLD);

    // Next-state: clear everything, or write back the addressed potential (zero if it fired).
    always_comb begin
        for (int i = 0; i < POSITIONS; i++) begin
            pot_d[i] = pot_q[i];
            if (clear_all) begin
                pot_d[i] = '0;
            end else if (upd_en && (idx == POS_W'(i))) begin
                pot_d[i] = spike ? '0 : new_pot;
            end
        end
    end

    // Potential registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < POSITIONS; i++) pot_q[i] <= '0;
        end else begin
            for (int i = 0; i < POSITIONS; i++) pot_q[i] <= pot_d[i];
        end
    end

endmodule

// File: rtl/spike_adder_node.sv
// Collects NUM_PE distinct psums per output neuron, integrates into its potential, emits a spike packet.
// Latency: pkt_out_valid high in the second cycle after the edge accepting the last psum; NUM_PE+2 cycles per output.
// Backpressure: pkt_in_ready low outside COLLECT or while clear_pot; pkt_out held stable until pkt_out_ready.
module spike_adder_node
    import snn_pkg::*;
#(
    parameter logic [3:0]           NODE_ADDRESS = 4'b0010,
    parameter logic [3:0]           OUT_ADDRESS  = 4'b1000,
    parameter int                   NUM_PE       = 5,
    parameter int                   PSUM_WIDTH   = 13,
    parameter int                   POT_WIDTH    = 16,
    parameter logic [POT_WIDTH-1:0] THRESHOLD    = 16'd64,
    parameter int                   POSITIONS    = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pkt_in,
    input  logic        pkt_in_valid,
    output logic        pkt_in_ready,
    output logic [63:0] pkt_out,
    output logic        pkt_out_valid,
    input  logic        pkt_out_ready,
    input  logic        clear_pot,
    output logic        err_drop
);

    node_state_e          state_q, state_d;
    logic                 rdy_q, rdy_d;
    logic [NUM_PE-1:0]    bitmap_q, bitmap_d;
    logic [POT_WIDTH-1:0] sum_q, sum_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [63:0]          pkt_out_q, pkt_out_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;

    logic [3:0]           in_dest, in_src;
    logic [1:0]           in_type;
    logic [POT_WIDTH-1:0] psum_ext;
    logic [NUM_PE-1:0]    src_oh;
    logic                 accept, pkt_ok;
    logic                 upd_en, clr_all;
    logic [POT_WIDTH-1:0] new_pot;
    logic                 spike;
    logic                 unused_pkt_bits;

    assign in_dest         = pkt_in[DEST_HI:DEST_LO];
    assign in_src          = pkt_in[SRC_HI:SRC_LO];
    assign in_type         = pkt_in[TYPE_HI:TYPE_LO];
    assign psum_ext        = POT_WIDTH'(pkt_in[PSUM_LO +: PSUM_WIDTH]);
    assign unused_pkt_bits = ^pkt_in[TYPE_LO-1:PSUM_LO+PSUM_WIDTH];

    // Source slot one-hot: src mod NUM_PE, so aliasing sources share a slot.
    always_comb begin
        int src_mod;
        src_mod = int'(in_src) % NUM_PE;
        src_oh  = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (src_mod == i) src_oh[i] = 1'b1;
        end
    end

    assign pkt_in_ready = rdy_q & ~clear_pot;
    assign accept       = pkt_in_valid & pkt_in_ready;
    assign pkt_ok       = (in_dest == NODE_ADDRESS) && (in_type == PKT_PSUM) && !(|(src_oh & bitmap_q));

    // Next-state and datapath control; clear_pot overrides every state.
    always_comb begin
        state_d   = state_q;
        bitmap_d  = bitmap_q;
        sum_d     = sum_q;
        pos_d     = pos_q;
        pkt_out_d = pkt_out_q;
        vld_d     = vld_q;
        err_d     = err_q;
        upd_en    = 1'b0;
        clr_all   = 1'b0;
        if (clear_pot) begin
            state_d  = ST_COLLECT;
            bitmap_d = '0;
            sum_d    = '0;
            pos_d    = '0;
            vld_d    = 1'b0;
            clr_all  = 1'b1;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (accept) begin
                        if (pkt_ok) begin
                            bitmap_d = bitmap_q | src_oh;
                            sum_d    = sum_q + psum_ext;
                            if (&bitmap_d) state_d = ST_UPDATE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    upd_en    = 1'b1;
                    pkt_out_d = spike_pkt(OUT_ADDRESS, NODE_ADDRESS, pos_q, spike);
                    vld_d     = 1'b1;
                    state_d   = ST_SEND;
                end
                ST_SEND: begin
                    if (pkt_out_ready) begin
                        vld_d    = 1'b0;
                        bitmap_d = '0;
                        sum_d    = '0;
                        pos_d    = (pos_q == POS_W'(POSITIONS - 1)) ? '0 : pos_q + 1'b1;
                        state_d  = ST_COLLECT;
                    end
                end
                default: state_d = ST_COLLECT;
            endcase
        end
        rdy_d = (state_d == ST_COLLECT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            rdy_q     <= 1'b0;
            bitmap_q  <= '0;
            sum_q     <= '0;
            pos_q     <= '0;
            pkt_out_q <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            bitmap_q  <= bitmap_d;
            sum_q     <= sum_d;
            pos_q     <= pos_d;
            pkt_out_q <= pkt_out_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
        end
    end

    membrane_bank #(
        .POT_WIDTH (POT_WIDTH),
        .POSITIONS (POSITIONS),
        .THRESHOLD (THRESHOLD)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_all (clr_all),
        .upd_en    (upd_en),
        .idx       (pos_q),
        .add_dat   (sum_q),
        .new_pot   (new_pot),
        .spike     (spike)
    );

    assign pkt_out       = pkt_out_q;
    assign pkt_out_valid = vld_q;
    assign err_drop      = err_q;

endmodule

// File: tb/tb_spike_adder_node.sv
// Directed bench for spike_adder_node: default instance plus a single-position, THRESHOLD=FFFF instance.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: pkt_out_ready driven per test.
module tb_spike_adder_node;

    logic        clk;
    logic        rst_n;
    logic [63:0] pkt_in, pkt_in_s;
    logic        pkt_in_valid, pkt_in_valid_s;
    logic        pkt_in_ready, pkt_in_ready_s;
    logic [63:0] pkt_out, pkt_out_s;
    logic        pkt_out_valid, pkt_out_valid_s;
    logic        pkt_out_ready, pkt_out_ready_s;
    logic        clear_pot, clear_pot_s;
    logic        err_drop, err_drop_s;

    int n_cmp = 0;
    int n_err = 0;

    // Sources used for a full group; 14 stands in for 12, which aliases 7 under mod-5 slotting.
    logic [3:0] grp_src [5] = '{4'd1, 4'd5, 4'd3, 4'd7, 4'd14};

    spike_adder_node dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt_in        (pkt_in),
        .pkt_in_valid  (pkt_in_valid),
        .pkt_in_ready  (pkt_in_ready),
        .pkt_out       (pkt_out),
        .pkt_out_valid (pkt_out_valid),
        .pkt_out_ready (pkt_out_ready),
        .clear_pot     (clear_pot),
        .err_drop      (err_drop)
    );

    spike_adder_node #(
        .THRESHOLD (16'hFFFF),
        .POSITIONS (1)
    ) dut_s (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt_in        (pkt_in_s),
        .pkt_in_valid  (pkt_in_valid_s),
        .pkt_in_ready  (pkt_in_ready_s),
        .pkt_out       (pkt_out_s),
        .pkt_out_valid (pkt_out_valid_s),
        .pkt_out_ready (pkt_out_ready_s),
        .clear_pot     (clear_pot_s),
        .err_drop      (err_drop_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_pkt(input logic [3:0] dst, input logic [3:0] src,
                                           input logic [1:0] typ, input logic [12:0] val);
        logic [63:0] p;
        p        = '0;
        p[63:60] = dst;
        p[59:56] = src;
        p[55:54] = typ;
        p[12:0]  = val;
        return p;
    endfunction

    function automatic logic [63:0] exp_spk(input int pos, input logic spk);
        logic [63:0] p;
        p        = '0;
        p[63:60] = 4'h8;
        p[59:56] = 4'h2;
        p[55:54] = 2'b11;
        p[5:1]   = 5'(pos);
        p[0]     = spk;
        return p;
    endfunction

    // Offer one packet; returns 1 time unit after the accepting edge.
    task automatic send_pkt(input bit sel, input logic [63:0] p);
        int n = 0;
        if (sel) begin pkt_in_s = p; pkt_in_valid_s = 1'b1; end
        else     begin pkt_in   = p; pkt_in_valid   = 1'b1; end
        while (!(sel ? pkt_in_ready_s : pkt_in_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("in_rdy_timeout", sel ? pkt_in_ready_s : pkt_in_ready, 1);
        @(posedge clk); #1;
        if (sel) pkt_in_valid_s = 1'b0;
        else     pkt_in_valid   = 1'b0;
    endtask

    task automatic send_group(input bit sel, input logic [12:0] val);
        for (int k = 0; k < 5; k++) send_pkt(sel, mk_pkt(4'h2, grp_src[k], 2'b10, val));
    endtask

    // Wait for an output, capture it, and complete the handshake (ready assumed high).
    task automatic get_out(input bit sel, output logic [63:0] p);
        int n = 0;
        while (!(sel ? pkt_out_valid_s : pkt_out_valid) && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 30) chk("out_vld_timeout", sel ? pkt_out_valid_s : pkt_out_valid, 1);
        p = sel ? pkt_out_s : pkt_out;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, p0;
        bit          stable;

        rst_n = 1'b0;
        pkt_in = '0;   pkt_in_valid = 1'b0;   pkt_out_ready = 1'b1;   clear_pot = 1'b0;
        pkt_in_s = '0; pkt_in_valid_s = 1'b0; pkt_out_ready_s = 1'b1; clear_pot_s = 1'b0;

        // Reset state
        #2;
        chk("rst_in_rdy", pkt_in_ready, 0);
        chk("rst_out_vld", pkt_out_valid, 0);
        chk("rst_pkt_out", pkt_out, 64'h0);
        chk("rst_err", err_drop, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rdy_before_edge", pkt_in_ready, 0);
        @(posedge clk); #1;
        chk("rdy_after_edge", pkt_in_ready, 1);

        // First group: pos 0, 5x10 = 50, no spike; latency check
        send_group(0, 13'd10);
        chk("lat_upd_vld", pkt_out_valid, 0);
        chk("lat_upd_rdy", pkt_in_ready, 0);
        @(posedge clk); #1;
        chk("lat_send_vld", pkt_out_valid, 1);
        get_out(0, got);
        chk("g0_pkt", got, exp_spk(0, 1'b0));
        chk("g0_pot", dut.u_bank.pot_q[0], 16'd50);
        chk("g0_back_rdy", pkt_in_ready, 1);
        chk("g0_vld_drop", pkt_out_valid, 0);

        // Positions 1..20, then wrap to pos 0 which reaches 100 and fires
        for (int ps = 1; ps < 21; ps++) begin
            send_group(0, 13'd10);
            get_out(0, got);
            chk($sformatf("grp_pos%0d", ps), got, exp_spk(ps, 1'b0));
        end
        send_group(0, 13'd10);
        get_out(0, got);
        chk("wrap_pkt", got, exp_spk(0, 1'b1));
        chk("wrap_pot", dut.u_bank.pot_q[0], 16'd0);

        // Drops: duplicate source, wrong type, wrong destination (pos 1 now)
        chk("err_clean", err_drop, 0);
        send_pkt(0, mk_pkt(4'h2, 4'd1, 2'b10, 13'd10));
        send_pkt(0, mk_pkt(4'h2, 4'd6, 2'b10, 13'd10));
        chk("err_dup", err_drop, 1);
        send_pkt(0, mk_pkt(4'h2, 4'd5, 2'b00, 13'd10));
        send_pkt(0, mk_pkt(4'h3, 4'd5, 2'b10, 13'd10));
        send_pkt(0, mk_pkt(4'h2, 4'd5, 2'b10, 13'd10));
        send_pkt(0, mk_pkt(4'h2, 4'd3, 2'b10, 13'd10));
        send_pkt(0, mk_pkt(4'h2, 4'd7, 2'b10, 13'd10));
        repeat (3) @(posedge clk); #1;
        chk("err_no_early_out", pkt_out_valid, 0);
        chk("err_still_rdy", pkt_in_ready, 1);
        send_pkt(0, mk_pkt(4'h2, 4'd14, 2'b10, 13'd10));
        get_out(0, got);
        chk("err_grp_pkt", got, exp_spk(1, 1'b1));
        chk("err_sticky", err_drop, 1);

        // Backpressure on pos 2
        pkt_out_ready = 1'b0;
        send_group(0, 13'd10);
        @(posedge clk); #1;
        p0 = pkt_out;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (pkt_out !== p0 || pkt_in_ready !== 1'b0 || pkt_out_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_pkt", pkt_out, exp_spk(2, 1'b1));
        pkt_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_vld_drop", pkt_out_valid, 0);
        chk("bp_rdy_back", pkt_in_ready, 1);
        send_group(0, 13'd10);
        get_out(0, got);
        chk("bp_next_pos", got, exp_spk(3, 1'b1));

        // clear_pot after two psums, with a packet offered during the clear
        send_pkt(0, mk_pkt(4'h2, 4'd1, 2'b10, 13'd10));
        send_pkt(0, mk_pkt(4'h2, 4'd5, 2'b10, 13'd10));
        pkt_in = mk_pkt(4'h2, 4'd3, 2'b10, 13'd10);
        pkt_in_valid = 1'b1;
        clear_pot = 1'b1;
        #1 chk("clr_rdy_low", pkt_in_ready, 0);
        @(posedge clk); #1;
        clear_pot = 1'b0; pkt_in_valid = 1'b0;
        chk("clr_pot5", dut.u_bank.pot_q[5], 16'd0);
        chk("clr_err_kept", err_drop, 1);
        send_group(0, 13'd10);
        get_out(0, got);
        chk("clr_grp_pkt", got, exp_spk(0, 1'b0));
        chk("clr_grp_pot", dut.u_bank.pot_q[0], 16'd50);

        // Reset asserted during UPDATE abandons the group
        send_group(0, 13'd10);
        rst_n = 1'b0;
        #1;
        chk("rstu_vld", pkt_out_valid, 0);
        chk("rstu_rdy", pkt_in_ready, 0);
        chk("rstu_err", err_drop, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rstu_no_out", pkt_out_valid, 0);
        chk("rstu_pot0", dut.u_bank.pot_q[0], 16'd0);
        send_group(0, 13'd10);
        get_out(0, got);
        chk("rstu_next_pkt", got, exp_spk(0, 1'b0));
        chk("rstu_next_pot", dut.u_bank.pot_q[0], 16'd50);

        // Saturation: 5x8191 = 40955 held, then 81910 clamps to FFFF and fires
        send_group(1, 13'd8191);
        get_out(1, got);
        chk("sat_g1_pkt", got, exp_spk(0, 1'b0));
        chk("sat_g1_pot", dut_s.u_bank.pot_q[0], 16'd40955);
        send_group(1, 13'd8191);
        chk("sat_newpot", dut_s.u_bank.new_pot, 16'hFFFF);
        get_out(1, got);
        chk("sat_g2_pkt", got, exp_spk(0, 1'b1));
        chk("sat_g2_pot", dut_s.u_bank.pot_q[0], 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
